// File: rtl/pipelined_adder.sv
// Ripple-carry adder split into STAGES registered slices with a valid/ready output handshake.
// Define OVERFLOW_FLAG_EN to add the ovf output (signed overflow, aligned with sum).
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned S = WIDTH / STAGES;

  logic             v_q [STAGES];
  logic             v_d [STAGES];
  logic             c_q [STAGES];
  logic             c_d [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];

  // Per-stage inputs: stage 0 sees the ports, stage k sees register k-1.
  logic             v_in [STAGES];
  logic             c_in [STAGES];
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];

  logic             stall;
  logic [S:0]       slice;
  logic [WIDTH-1:0] part_s;

`ifdef OVERFLOW_FLAG_EN
  logic ovf_q;
  logic ovf_d;
`endif

  always_comb begin
    v_in[0] = in_valid;
    c_in[0] = cin;
    a_in[0] = a;
    b_in[0] = b;
    s_in[0] = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      v_in[k] = v_q[k-1];
      c_in[k] = c_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
    end
  end

  always_comb begin
    stall  = v_q[STAGES-1] && !out_ready;
    slice  = '0;
    part_s = '0;
`ifdef OVERFLOW_FLAG_EN
    ovf_d  = ovf_q;
`endif
    for (int unsigned k = 0; k < STAGES; k++) begin
      v_d[k] = v_q[k];
      c_d[k] = c_q[k];
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      if (!stall) begin
        slice  = {1'b0, a_in[k][k*S +: S]} + {1'b0, b_in[k][k*S +: S]} + {{S{1'b0}}, c_in[k]};
        part_s = s_in[k];
        part_s[k*S +: S] = slice[S-1:0];
        v_d[k] = v_in[k];
        c_d[k] = slice[S];
        a_d[k] = a_in[k];
        b_d[k] = b_in[k];
        s_d[k] = part_s;
`ifdef OVERFLOW_FLAG_EN
        if (k == STAGES - 1) begin
          ovf_d = (a_in[k][WIDTH-1] == b_in[k][WIDTH-1]) && (part_s[WIDTH-1] != a_in[k][WIDTH-1]);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
`ifdef OVERFLOW_FLAG_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
`ifdef OVERFLOW_FLAG_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign in_ready  = !stall;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign carry     = c_q[STAGES-1];
`ifdef OVERFLOW_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=32, STAGES=4) with a queue-based scoreboard.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sum;
  logic        carry;
  logic        out_valid;
  logic        out_ready;
`ifdef OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum      (sum),
    .carry    (carry),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf      (ovf)
`endif
  );

  logic [33:0] sbq[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    logic [32:0] full;
    logic        ov;
    full = {1'b0, av} + {1'b0, bv} + {32'd0, cv};
    ov   = (av[31] == bv[31]) && (full[31] != av[31]);
    return {ov, full};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs (called just after a falling edge), then score the handshake.
  task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                       input logic iv, input logic ordy);
    logic [33:0] e;
    a = av; b = bv; cin = cv; in_valid = iv; out_ready = ordy;
    #1;
    if (!rst) begin
      if (out_valid === 1'b1 && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 64'(out_valid), 64'(0));
        end else begin
          e = sbq.pop_front();
          chk("sum", 64'(sum), 64'(e[31:0]));
          chk("carry", 64'(carry), 64'(e[32]));
`ifdef OVERFLOW_FLAG_EN
          chk("ovf", 64'(ovf), 64'(e[33]));
`endif
        end
      end
      if (in_valid && in_ready === 1'b1) sbq.push_back(model(av, bv, cv));
    end
  endtask

  task automatic step(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                      input logic iv, input logic ordy);
    drive(av, bv, cv, iv, ordy);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    // Reset: operands presented during reset must not be accepted
    step(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 1'b1);
    step(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_carry", 64'(carry), 64'(0));
    @(negedge clk);

    // Latency: result exactly 4 cycles after acceptance
    step(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive('0, '0, 1'b0, 1'b0, 1'b1);
      chk("lat_early", 64'(out_valid), 64'(0));
      @(negedge clk);
    end
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    chk("lat_valid", 64'(out_valid), 64'(1));
    chk("lat_sum", 64'(sum), 64'(32'h0000_0000));
    chk("lat_carry", 64'(carry), 64'(1));
    @(negedge clk);

    // Back-to-back: 8 consecutive results, sum = 0x11*i + (i&1)
    for (int i = 0; i < 8; i++) begin
      if (i >= 4) chk("b2b_valid", 64'(out_valid), 64'(1));
      drive(32'(i), 32'(16 * i), 1'(i & 1), 1'b1, 1'b1);
      if (i >= 4) chk("b2b_sum", 64'(sum), 64'(17 * (i - 4) + ((i - 4) & 1)));
      @(negedge clk);
    end
    for (int i = 4; i < 8; i++) begin
      drive('0, '0, 1'b0, 1'b0, 1'b1);
      chk("b2b_valid", 64'(out_valid), 64'(1));
      chk("b2b_sum", 64'(sum), 64'(17 * i + (i & 1)));
      @(negedge clk);
    end
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    chk("b2b_end", 64'(out_valid), 64'(0));
    @(negedge clk);

    // Stall: stream with a bubble, then out_ready low for 3 cycles
    for (int i = 0; i < 6; i++) begin
      step($urandom, $urandom, 1'($urandom_range(0, 1)), 1'(i != 3), 1'b1);
    end
    ra = $urandom; rb = $urandom;
    for (int i = 0; i < 3; i++) begin
      drive(ra, rb, 1'b1, 1'b1, 1'b0);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_sum", 64'(sum), 64'(sbq[0][31:0]));
      chk("stall_carry", 64'(carry), 64'(sbq[0][32]));
      @(negedge clk);
    end
    step(ra, rb, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step('0, '0, 1'b0, 1'b0, 1'b1);
    chk("stall_drained", 64'(sbq.size()), 64'(0));

    // Reset with 3 sets in flight
    for (int i = 0; i < 3; i++) step($urandom, $urandom, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    step($urandom, $urandom, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    sbq.delete();
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    for (int i = 0; i < 6; i++) step('0, '0, 1'b0, 1'b0, 1'b1);

`ifdef OVERFLOW_FLAG_EN
    step(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
    step(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    step('0, '0, 1'b0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0, 1'b1);
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    chk("ovf_pos_sum", 64'(sum), 64'(32'h8000_0000));
    chk("ovf_pos_flag", 64'(ovf), 64'(1));
    chk("ovf_pos_carry", 64'(carry), 64'(0));
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    chk("ovf_neg_sum", 64'(sum), 64'(0));
    chk("ovf_neg_flag", 64'(ovf), 64'(1));
    chk("ovf_neg_carry", 64'(carry), 64'(1));
    @(negedge clk);
`endif

    // Random traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      step($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 10; i++) step('0, '0, 1'b0, 1'b0, 1'b1);
    chk("final_drained", 64'(sbq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
